// File: rtl/alu_req_arbiter_pkg.sv
// rtl/alu_req_arbiter_pkg.sv - shared types and constants for alu_req_arbiter
// Purpose: FSM state type, flag bit positions, multiply command codes and
//          INP_VALID encodings used by the arbiter and its sub-modules.
// Ports:   none (package alu_arb_pkg).
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Bit positions inside rsp_flags = {COUT, ERR, OFLOW, G, E, L}
   localparam int FLAG_L     = 0;
   localparam int FLAG_E     = 1;
   localparam int FLAG_G     = 2;
   localparam int FLAG_OFLOW = 3;
   localparam int FLAG_ERR   = 4;
   localparam int FLAG_COUT  = 5;

   // Arithmetic-mode commands that take the longer multiply latency
   localparam int CMD_MUL_INC = 9;
   localparam int CMD_MUL_SHL = 10;

   localparam logic [1:0] INP_VALID_BOTH = 2'b11;
   localparam logic [1:0] INP_VALID_NONE = 2'b00;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// rtl/alu_req_arbiter_if.sv - requester and ALU signal bundle for alu_req_arbiter
// Purpose: groups the per-requester request/response bus and the ALU pin bus.
// Ports (signals):
//   req_valid/req_ready/req_opa/req_opb/req_cmd/req_mode/req_cin : request side
//   rsp_valid/rsp_res/rsp_flags/busy                             : response side
//   alu_opa/alu_opb/alu_cmd/alu_mode/alu_cin/alu_ce/alu_inp_valid : to ALU
//   alu_res/alu_cout/alu_err/alu_oflow/alu_g/alu_e/alu_l          : from ALU
// Modports: master = requesters + ALU, slave = arbiter.
interface alu_req_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int CW   = 4,
   parameter int RW   = 16
) ();
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*DW-1:0] req_opa;
   logic [NREQ*DW-1:0] req_opb;
   logic [NREQ*CW-1:0] req_cmd;
   logic [NREQ-1:0]    req_mode;
   logic [NREQ-1:0]    req_cin;
   logic [NREQ-1:0]    rsp_valid;
   logic [RW-1:0]      rsp_res;
   logic [5:0]         rsp_flags;
   logic               busy;
   logic [DW-1:0]      alu_opa;
   logic [DW-1:0]      alu_opb;
   logic [CW-1:0]      alu_cmd;
   logic               alu_mode;
   logic               alu_cin;
   logic               alu_ce;
   logic [1:0]         alu_inp_valid;
   logic [RW-1:0]      alu_res;
   logic               alu_cout;
   logic               alu_err;
   logic               alu_oflow;
   logic               alu_g;
   logic               alu_e;
   logic               alu_l;

   modport master (
      output req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin,
      output alu_res, alu_cout, alu_err, alu_oflow, alu_g, alu_e, alu_l,
      input  req_ready, rsp_valid, rsp_res, rsp_flags, busy,
      input  alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_ce, alu_inp_valid
   );

   modport slave (
      input  req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin,
      input  alu_res, alu_cout, alu_err, alu_oflow, alu_g, alu_e, alu_l,
      output req_ready, rsp_valid, rsp_res, rsp_flags, busy,
      output alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_ce, alu_inp_valid
   );
endinterface

// File: rtl/alu_req_arbiter_rr_arbiter.sv
// rtl/alu_req_arbiter_rr_arbiter.sv - combinational round-robin grant
// Purpose: picks the first set request at or after i_ptr, wrapping modulo NREQ.
// Ports:
//   i_req   in  NREQ  request vector
//   i_ptr   in  PW    search start index (pointer register lives in the parent)
//   o_grant out NREQ  one-hot grant (zero when no request)
//   o_idx   out PW    index of the granted requester
//   o_any   out 1     at least one request present
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [PW-1:0]   o_idx,
   output logic            o_any
);
   // One extra bit so ptr + offset cannot overflow before the modulo fold
   logic [PW:0] w_sum;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_sum   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_sum = {1'b0, i_ptr} + (PW+1)'(k);
         if (w_sum >= (PW+1)'(NREQ)) begin
            w_sum = w_sum - (PW+1)'(NREQ);
         end
         if (!o_any && i_req[w_sum[PW-1:0]]) begin
            o_any                = 1'b1;
            o_idx                = w_sum[PW-1:0];
            o_grant[w_sum[PW-1:0]] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin sharing of one ALU among NREQ requesters
// Purpose: grants one request at a time, drives the ALU pins for the
//          command-dependent latency, captures result and flags, and pulses
//          rsp_valid to the requester that won.
// Ports:
//   CLK  in  clock
//   RST  in  synchronous active-high reset
//   bus  alu_req_arbiter_if.slave (request, response and ALU pin buses)
// Optional macro: ALU_ARB_PRIO0_EN gives requester 0 absolute priority.
module alu_req_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DW      = 8,
   parameter int CW      = 4,
   parameter int RW      = 16,
   parameter int LAT     = 1,
   parameter int MUL_LAT = 2
) (
   input  logic             CLK,
   input  logic             RST,
   alu_req_arbiter_if.slave bus
);
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNTW = 8;

   state_t          r_state, w_next;
   logic [PW-1:0]   r_ptr, r_owner;
   logic [DW-1:0]   r_opa, r_opb;
   logic [CW-1:0]   r_cmd;
   logic            r_mode, r_cin;
   logic [CNTW-1:0] r_cnt;
   logic [RW-1:0]   r_rsp_res;
   logic [5:0]      r_rsp_flags;

   logic [NREQ-1:0] w_rr_grant, w_grant, w_ready, w_rsp_valid;
   logic [PW-1:0]   w_rr_idx, w_idx;
   logic            w_rr_any, w_any, w_ptr_upd, w_take, w_is_mul, w_last;
   logic            w_ce;
   logic [1:0]      w_inp_valid;
   logic [5:0]      w_flags;

   rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
      .i_req   (bus.req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_rr_grant),
      .o_idx   (w_rr_idx),
      .o_any   (w_rr_any)
   );

`ifdef ALU_ARB_PRIO0_EN
   // Requester 0 bypasses the rotation and leaves the pointer untouched,
   // so the others keep their round-robin position.
   assign w_grant   = bus.req_valid[0] ? NREQ'(1) : w_rr_grant;
   assign w_idx     = bus.req_valid[0] ? '0 : w_rr_idx;
   assign w_any     = w_rr_any;
   assign w_ptr_upd = !bus.req_valid[0];
`else
   assign w_grant   = w_rr_grant;
   assign w_idx     = w_rr_idx;
   assign w_any     = w_rr_any;
   assign w_ptr_upd = 1'b1;
`endif

   assign w_take   = (r_state == IDLE) && w_any;
   assign w_is_mul = r_mode && ((r_cmd == CW'(CMD_MUL_INC)) || (r_cmd == CW'(CMD_MUL_SHL)));
   assign w_last   = (r_state == WAIT) && (r_cnt == CNTW'(1));

   always_comb begin
      w_flags             = '0;
      w_flags[FLAG_COUT]  = bus.alu_cout;
      w_flags[FLAG_ERR]   = bus.alu_err;
      w_flags[FLAG_OFLOW] = bus.alu_oflow;
      w_flags[FLAG_G]     = bus.alu_g;
      w_flags[FLAG_E]     = bus.alu_e;
      w_flags[FLAG_L]     = bus.alu_l;
   end

   always_ff @(posedge CLK) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_ready     = '0;
      w_rsp_valid = '0;
      w_ce        = 1'b0;
      w_inp_valid = INP_VALID_NONE;
      case (r_state)
         IDLE: begin
            // Grant is suppressed while reset is asserted because that edge
            // does not accept the payload.
            if (!RST) w_ready = w_grant;
            if (w_any) w_next = ISSUE;
         end
         ISSUE: begin
            w_ce        = 1'b1;
            w_inp_valid = INP_VALID_BOTH;
            w_next      = WAIT;
         end
         WAIT: begin
            w_ce        = 1'b1;
            w_inp_valid = INP_VALID_BOTH;
            if (w_last) w_next = RESP;
         end
         RESP: begin
            w_rsp_valid[r_owner] = 1'b1;
            w_next               = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ptr       <= '0;
         r_owner     <= '0;
         r_opa       <= '0;
         r_opb       <= '0;
         r_cmd       <= '0;
         r_mode      <= 1'b0;
         r_cin       <= 1'b0;
         r_cnt       <= '0;
         r_rsp_res   <= '0;
         r_rsp_flags <= '0;
      end else begin
         if (w_take) begin
            r_opa   <= bus.req_opa[w_idx*DW +: DW];
            r_opb   <= bus.req_opb[w_idx*DW +: DW];
            r_cmd   <= bus.req_cmd[w_idx*CW +: CW];
            r_mode  <= bus.req_mode[w_idx];
            r_cin   <= bus.req_cin[w_idx];
            r_owner <= w_idx;
            if (w_ptr_upd) begin
               r_ptr <= (w_idx == PW'(NREQ-1)) ? '0 : w_idx + 1'b1;
            end
         end
         if (r_state == ISSUE) begin
            r_cnt <= w_is_mul ? CNTW'(MUL_LAT) : CNTW'(LAT);
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 1'b1;
         end
         // Captured on the WAIT->RESP edge so the value is already on the
         // bus during the single rsp_valid cycle, then held until next time.
         if (w_last) begin
            r_rsp_res   <= bus.alu_res;
            r_rsp_flags <= w_flags;
         end
      end
   end

   assign bus.req_ready     = w_ready;
   assign bus.rsp_valid     = w_rsp_valid;
   assign bus.rsp_res       = r_rsp_res;
   assign bus.rsp_flags     = r_rsp_flags;
   assign bus.busy          = (r_state != IDLE);
   assign bus.alu_opa       = r_opa;
   assign bus.alu_opb       = r_opb;
   assign bus.alu_cmd       = r_cmd;
   assign bus.alu_mode      = r_mode;
   assign bus.alu_cin       = r_cin;
   assign bus.alu_ce        = w_ce;
   assign bus.alu_inp_valid = w_inp_valid;
endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares a single ALU_DESIGN instance between NREQ independent requesters.
- Round-robin arbitration; one operation in flight at a time.
- Drives the ALU control/operand pins, waits the command-dependent latency, then captures RES and the flags and routes them back to the requester that won.
- Sits between requester logic (or bench drivers) and the ALU datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, operand width (matches ALU `WIDTH).
- CW, 4, command width (matches ALU `CMD_WIDTH).
- RW, 16, ALU result width (2*DW).
- LAT, 1, ALU latency in cycles for normal commands.
- MUL_LAT, 2, ALU latency in cycles for multiply commands.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_opa  in  NREQ*DW  packed operand A, requester i at [i*DW +: DW].
- req_opb  in  NREQ*DW  packed operand B.
- req_cmd  in  NREQ*CW  packed command.
- req_mode  in  NREQ  1 = arithmetic, 0 = logical.
- req_cin  in  NREQ  carry-in.
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse.
- rsp_res  out  RW  captured result (shared bus, qualified by rsp_valid).
- rsp_flags  out  6  {COUT, ERR, OFLOW, G, E, L}.
- busy  out  1  high whenever state != IDLE.
- alu_opa / alu_opb  out  DW  to ALU OPA/OPB.
- alu_cmd  out  CW  to ALU CMD.
- alu_mode  out  1  to ALU MODE.
- alu_cin  out  1  to ALU CIN.
- alu_ce  out  1  to ALU CE.
- alu_inp_valid  out  2  to ALU INP_VALID.
- alu_res  in  RW  from ALU RES.
- alu_cout, alu_err, alu_oflow, alu_g, alu_e, alu_l  in  1 each  from ALU flags.

Interface rule: one clock CLK; reset RST is synchronous, active-high.

Behaviour:
- Reset: all outputs 0.
  - state = IDLE; rr_ptr = 0; hold registers 0.
  - RST asserted mid-operation aborts it: no rsp_valid is produced and the ALU outputs are driven to 0 in the next cycle.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - The winner is the first i with req_valid[i], scanning from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[winner] = 1 combinationally in the same cycle.
  - On that edge: latch opa/opb/cmd/mode/cin and the owner index; set rr_ptr = winner+1 (mod NREQ); go to ISSUE.
  - No valid request: stay in IDLE, req_ready = 0.
- ISSUE (1 cycle):
  - alu_ce = 1, alu_inp_valid = 2'b11, operands driven from hold registers.
  - Latency counter loaded: MUL_LAT if mode=1 and cmd is 9 or 10, else LAT.
  - Next state WAIT.
- WAIT:
  - ce, inp_valid and operands held stable; counter decrements each cycle.
  - At counter == 1, go to RESP.
- RESP (1 cycle):
  - Capture alu_res and flags into rsp_res / rsp_flags.
  - rsp_valid[owner] = 1 for exactly this cycle.
  - alu_ce = 0, alu_inp_valid = 2'b00; next state IDLE.
- Data retention: rsp_res and rsp_flags hold their last captured value until the next RESP.
- Ready gating: req_ready is only ever asserted in IDLE, so a request arriving while busy waits. Requesters must hold req_valid and the payload until req_ready.
- Throughput: one operation per 3+latency cycles.
- Simultaneous requests: exactly one is granted. Round-robin guarantees each valid requester is served within NREQ grants.
- A requester may deassert req_valid before it is granted; there is no penalty.

Optional Feature:
- Macro ALU_ARB_PRIO0_EN.
- When defined: requester 0 has absolute priority. If req_valid[0] = 1 it wins regardless of rr_ptr, and rr_ptr is not updated on its grant. All other requesters remain round-robin among themselves.
- When undefined: pure round-robin as above.

Decomposition:
- Package alu_arb_pkg holds:
  - typedef for state_t {IDLE, ISSUE, WAIT, RESP};
  - flag-bit index constants;
  - MUL command codes (9, 10);
  - INP_VALID constants (2'b11 / 2'b00).
- Sub-module rr_arbiter (NREQ-wide round-robin grant from request vector and pointer; combinational grant, registered pointer in parent) is the natural split.

Test Plan:
- Single request: req 2, opa=8'h05, opb=8'h03, cmd=0 (ADD), mode=1 -> req_ready[2] in the accept cycle; rsp_valid[2] exactly LAT+2 cycles later; rsp_res=16'h0008; flags COUT=0.
- Multiply latency: req 1, opa=8'h04, opb=8'h02, cmd=9, mode=1 -> ce/inp_valid held for MUL_LAT cycles; rsp_valid[1] one cycle later than a normal command.
- All four requesters valid with distinct ops from reset:
  - without ALU_ARB_PRIO0_EN -> grant order 0,1,2,3, responses in the same order, each rsp_res correct;
  - with the macro and req 0 held valid -> req 0 is granted every round.
- Request during busy: req 3 asserts in WAIT -> req_ready[3] stays 0 until IDLE, then it is granted; the payload is sampled at the grant edge, not earlier.
- Reset mid-op: RST=1 for one cycle during WAIT -> no rsp_valid; busy=0; alu_ce=0 the next cycle; a subsequent request is granted starting from rr_ptr=0.
- Wrap-around: rr_ptr=3 with req 0 and req 3 valid -> req 3 granted first, then req 0.
